// File: rtl/mode_select_pkg.sv
// Shared constants and helpers for the mode selection block.
package mode_select_pkg;

    // Encoding of "no feature mode selected" on active_mode.
    localparam int unsigned MODE_IDLE = 0;

    // Bits needed to encode the values 0 .. n_values-1 (never less than one bit).
    function automatic int unsigned index_width(input int unsigned n_values);
        int unsigned w = 1;
        while (w < 32 && (32'd1 << w) < n_values) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mode_debounce.sv
// Debounce of the registered mode candidate: a candidate must hold steady
// before it becomes a pending switch, and any wobble abandons the switch.
module mode_debounce
    import mode_select_pkg::*;
#(
    parameter int unsigned MW            = 3,
    parameter int unsigned STABLE_CYCLES = 1_000_000
) (
    input  logic          clock_100mhz,
    input  logic          reset,
    input  logic [MW-1:0] candidate,
    input  logic [MW-1:0] active_mode,
    input  logic          commit,
    output logic          pending_valid,
    output logic [MW-1:0] pending_mode,
    output logic          candidate_changed
);

    localparam int unsigned CW = index_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [MW-1:0] candidate_q;
    logic [CW-1:0] stable_cnt;

    // A fresh candidate value restarts the stability count and kills any pending switch.
    assign candidate_changed = (candidate != candidate_q);

    // Stability counter, saturating once the candidate has held long enough.
    always_ff @(posedge clock_100mhz) begin
        if (reset) begin
            candidate_q <= MW'(MODE_IDLE);
            stable_cnt  <= '0;
        end else begin
            candidate_q <= candidate;
            if (candidate_changed) begin
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_MAX) begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

    // Pending switch: raised by a settled candidate that differs from the active mode,
    // dropped by a commit or by any candidate movement before the commit happens.
    always_ff @(posedge clock_100mhz) begin
        if (reset) begin
            pending_valid <= 1'b0;
            pending_mode  <= MW'(MODE_IDLE);
        end else if (commit) begin
            pending_valid <= 1'b0;
        end else if (candidate_changed) begin
            pending_valid <= 1'b0;
        end else if (stable_cnt == CNT_MAX && candidate != active_mode) begin
            pending_valid <= 1'b1;
            pending_mode  <= candidate;
        end
    end

endmodule

// File: rtl/mode_select_mux.sv
// Password-driven feature mode selector: decodes the switch word into a mode,
// debounces it, commits it (optionally on a frame boundary) and muxes the
// selected mode's LED and pixel words onto registered outputs.
module mode_select_mux
    import mode_select_pkg::*;
#(
    parameter int unsigned NUM_MODES     = 4,
    parameter int unsigned SW_WIDTH      = 16,
    parameter int unsigned LED_WIDTH     = 16,
    parameter int unsigned PIX_WIDTH     = 16,
    parameter int unsigned STABLE_CYCLES = 1_000_000,
    parameter int unsigned FRAME_ALIGN   = 1,
    localparam int unsigned MW           = index_width(NUM_MODES + 1)
) (
    input  logic                           clock_100mhz,
    input  logic                           reset,
    input  logic [SW_WIDTH-1:0]            sw,
    input  logic [NUM_MODES*SW_WIDTH-1:0]  passwords,
    input  logic [NUM_MODES-1:0]           mode_enable,
    input  logic                           frame_begin,
    input  logic [NUM_MODES*LED_WIDTH-1:0] led_in,
    input  logic [NUM_MODES*PIX_WIDTH-1:0] oled_in,
    input  logic [PIX_WIDTH-1:0]           oled_data_init,
    output logic [LED_WIDTH-1:0]           led,
    output logic [PIX_WIDTH-1:0]           oled_data,
    output logic [MW-1:0]                  active_mode,
    output logic                           mode_changed
);

    logic [MW-1:0]        candidate_next;
    logic [MW-1:0]        candidate_reg;
    logic                 pending_valid;
    logic [MW-1:0]        pending_mode;
    logic                 candidate_changed;
    logic                 frame_ok;
    logic                 commit;
    logic [LED_WIDTH-1:0] led_sel;
    logic [PIX_WIDTH-1:0] pix_sel;

    // Lowest-numbered enabled mode whose password matches the switches wins;
    // scanning from the top down lets the lowest match overwrite the others.
    always_comb begin
        candidate_next = MW'(MODE_IDLE);
        for (int k = NUM_MODES; k >= 1; k--) begin
            if (mode_enable[k-1] && sw == passwords[(k-1)*SW_WIDTH +: SW_WIDTH]) begin
                candidate_next = MW'(k);
            end
        end
    end

    mode_debounce #(
        .MW            (MW),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_debounce (
        .clock_100mhz      (clock_100mhz),
        .reset             (reset),
        .candidate         (candidate_reg),
        .active_mode       (active_mode),
        .commit            (commit),
        .pending_valid     (pending_valid),
        .pending_mode      (pending_mode),
        .candidate_changed (candidate_changed)
    );

    // With frame alignment the switch waits for the display's frame strobe so
    // the screen never tears mid-frame; otherwise any cycle is acceptable.
    assign frame_ok = (FRAME_ALIGN == 0) ? 1'b1 : frame_begin;
    assign commit   = pending_valid && frame_ok && !candidate_changed;

    // Pick the LED and pixel words that belong to the currently active mode.
    always_comb begin
        led_sel = '0;
        pix_sel = '0;
        for (int k = 0; k < NUM_MODES; k++) begin
            if (active_mode == MW'(k + 1)) begin
                led_sel = led_in[k*LED_WIDTH +: LED_WIDTH];
                pix_sel = oled_in[k*PIX_WIDTH +: PIX_WIDTH];
            end
        end
    end

    // Candidate register, mode commit and the registered output mux; the idle
    // screen mirrors the switches on the LEDs and shows the init pixel.
    always_ff @(posedge clock_100mhz) begin
        if (reset) begin
            candidate_reg <= MW'(MODE_IDLE);
            active_mode   <= MW'(MODE_IDLE);
            mode_changed  <= 1'b0;
            led           <= '0;
            oled_data     <= '0;
        end else begin
            candidate_reg <= candidate_next;
            mode_changed  <= commit;
            if (commit) begin
                active_mode <= pending_mode;
            end
            if (active_mode == MW'(MODE_IDLE)) begin
                led       <= LED_WIDTH'(sw);
                oled_data <= oled_data_init;
            end else begin
                led       <= led_sel;
                oled_data <= pix_sel;
            end
        end
    end

endmodule

// File: tb/tb_mode_select_mux.sv
// Bench for mode_select_mux: one frame-aligned and one immediate-commit instance
// share stimulus; a history-window model checks both every cycle, and literal
// expectations pin key moments of each directed scenario.
module tb_mode_select_mux;

    localparam int STABLE = 4;
    localparam logic [15:0] PW_TAB   [4] = '{16'h138D, 16'h2265, 16'h0000, 16'h8195};
    localparam logic [15:0] LED_TAB  [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    localparam logic [15:0] OLED_TAB [4] = '{16'hA001, 16'hB002, 16'hC003, 16'hD004};
    localparam logic [15:0] INIT_PIX     = 16'hFFFF;

    logic        clk;
    logic        reset;
    logic [15:0] sw;
    logic [3:0]  mode_enable;
    logic        frame_begin;
    logic [63:0] passwords;
    logic [63:0] led_in;
    logic [63:0] oled_in;

    logic [1:0][15:0] dut_led;
    logic [1:0][15:0] dut_oled;
    logic [1:0][2:0]  dut_act;
    logic [1:0]       dut_chg;
    logic [1:0]       dut_pend;

    int n_checks = 0;
    int n_fail   = 0;

    assign passwords = {PW_TAB[3], PW_TAB[2], PW_TAB[1], PW_TAB[0]};
    assign led_in    = {LED_TAB[3], LED_TAB[2], LED_TAB[1], LED_TAB[0]};
    assign oled_in   = {OLED_TAB[3], OLED_TAB[2], OLED_TAB[1], OLED_TAB[0]};

    // Instance 0 waits for frame strobes, instance 1 commits immediately.
    mode_select_mux #(
        .NUM_MODES(4), .SW_WIDTH(16), .LED_WIDTH(16), .PIX_WIDTH(16),
        .STABLE_CYCLES(STABLE), .FRAME_ALIGN(1)
    ) dut_fa1 (
        .clock_100mhz(clk), .reset(reset), .sw(sw), .passwords(passwords),
        .mode_enable(mode_enable), .frame_begin(frame_begin), .led_in(led_in),
        .oled_in(oled_in), .oled_data_init(INIT_PIX), .led(dut_led[0]),
        .oled_data(dut_oled[0]), .active_mode(dut_act[0]), .mode_changed(dut_chg[0])
    );

    mode_select_mux #(
        .NUM_MODES(4), .SW_WIDTH(16), .LED_WIDTH(16), .PIX_WIDTH(16),
        .STABLE_CYCLES(STABLE), .FRAME_ALIGN(0)
    ) dut_fa0 (
        .clock_100mhz(clk), .reset(reset), .sw(sw), .passwords(passwords),
        .mode_enable(mode_enable), .frame_begin(frame_begin), .led_in(led_in),
        .oled_in(oled_in), .oled_data_init(INIT_PIX), .led(dut_led[1]),
        .oled_data(dut_oled[1]), .active_mode(dut_act[1]), .mode_changed(dut_chg[1])
    );

    assign dut_pend = {dut_fa0.u_debounce.pending_valid, dut_fa1.u_debounce.pending_valid};

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: decoded candidate history since reset plus per-instance outcome.
    int cand_hist[$];
    int cand_r;
    int m_act   [2];
    int m_pend  [2];
    int m_pmode [2];
    int m_chg   [2];
    int m_led   [2];
    int m_oled  [2];
    bit model_ready = 1'b0;

    function automatic int expCandidate(input logic [15:0] s, input logic [3:0] en);
        for (int k = 1; k <= 4; k++) begin
            if (en[k-1] && s == PW_TAB[k-1]) return k;
        end
        return 0;
    endfunction

    task automatic checkOutput(input string name, input int unsigned actual, input int unsigned expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic modelStep();
        int  n;
        int  last;
        bit  change;
        bit  stable;
        bit  commit;
        bit  frame_ok;
        if (reset) begin
            cand_r = 0;
            cand_hist.delete();
            cand_hist.push_back(0);
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 0; m_pend[i] = 0; m_pmode[i] = 0;
                m_chg[i] = 0; m_led[i] = 0;  m_oled[i] = 0;
            end
            model_ready = 1'b1;
            return;
        end
        cand_hist.push_back(cand_r);
        if (cand_hist.size() > STABLE + 2) void'(cand_hist.pop_front());
        n      = cand_hist.size();
        last   = cand_hist[n-1];
        change = (last != cand_hist[n-2]);
        stable = (n >= STABLE + 1);
        if (stable) begin
            for (int j = n - STABLE - 1; j < n; j++) begin
                if (cand_hist[j] != last) stable = 1'b0;
            end
        end
        for (int i = 0; i < 2; i++) begin
            frame_ok = (i == 0) ? frame_begin : 1'b1;
            commit   = m_pend[i] != 0 && frame_ok && !change;
            if (m_act[i] == 0) begin
                m_led[i]  = sw;
                m_oled[i] = INIT_PIX;
            end else begin
                m_led[i]  = LED_TAB[m_act[i]-1];
                m_oled[i] = OLED_TAB[m_act[i]-1];
            end
            m_chg[i] = commit;
            if (commit) begin
                m_act[i]  = m_pmode[i];
                m_pend[i] = 0;
            end else if (change) begin
                m_pend[i] = 0;
            end else if (stable && last != m_act[i]) begin
                m_pend[i]  = 1;
                m_pmode[i] = last;
            end
        end
        cand_r = expCandidate(sw, mode_enable);
    endtask

    // Every cycle: step the model at the edge, compare both instances just after it.
    always @(posedge clk) begin
        modelStep();
        #1;
        if (model_ready) begin
            for (int i = 0; i < 2; i++) begin
                checkOutput($sformatf("model active[%0d]", i), dut_act[i], m_act[i]);
                checkOutput($sformatf("model changed[%0d]", i), dut_chg[i], m_chg[i]);
                checkOutput($sformatf("model led[%0d]", i), dut_led[i], m_led[i]);
                checkOutput($sformatf("model oled[%0d]", i), dut_oled[i], m_oled[i]);
                checkOutput($sformatf("model pending[%0d]", i), dut_pend[i], m_pend[i]);
            end
        end
    end

    // Drive one cycle of inputs at the falling edge and return at the next falling edge.
    task automatic applyStimulus(input logic [15:0] s, input logic fb);
        sw          = s;
        frame_begin = fb;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        reset       = 1'b1;
        sw          = 16'h0000;
        mode_enable = 4'b1011;
        frame_begin = 1'b0;
        @(negedge clk);
        repeat (2) applyStimulus(16'h0000, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset active", dut_act[i], 0);
            checkOutput("reset led", dut_led[i], 0);
            checkOutput("reset oled", dut_oled[i], 0);
            checkOutput("reset changed", dut_chg[i], 0);
        end

        // Mode 1 password held; frame strobe on the pending edge must not commit.
        reset = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            applyStimulus(16'h138D, c == 6 || c == 10);
            case (c)
                1: begin
                    checkOutput("idle led follows sw", dut_led[0], 16'h138D);
                    checkOutput("idle oled init", dut_oled[0], 16'hFFFF);
                end
                6: begin
                    checkOutput("pending set fa1", dut_pend[0], 1);
                    checkOutput("no commit on set edge", dut_act[0], 0);
                end
                7: begin
                    checkOutput("fa0 commit", dut_act[1], 1);
                    checkOutput("fa0 pulse", dut_chg[1], 1);
                    checkOutput("fa1 waits", dut_act[0], 0);
                end
                8: begin
                    checkOutput("fa0 pulse ends", dut_chg[1], 0);
                    checkOutput("fa0 led mode1", dut_led[1], 16'h1111);
                    checkOutput("fa0 oled mode1", dut_oled[1], 16'hA001);
                end
                10: begin
                    checkOutput("fa1 commit", dut_act[0], 1);
                    checkOutput("fa1 pulse", dut_chg[0], 1);
                end
                11: begin
                    checkOutput("fa1 pulse ends", dut_chg[0], 0);
                    checkOutput("fa1 led mode1", dut_led[0], 16'h1111);
                end
                default: ;
            endcase
        end

        // Reset with a mode active clears everything even with live switches.
        reset = 1'b1;
        repeat (2) applyStimulus(16'h5A5A, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset2 active", dut_act[i], 0);
            checkOutput("reset2 led", dut_led[i], 0);
        end
        reset = 1'b0;

        // Mode 4 password glimpsed for two cycles only.
        repeat (2) applyStimulus(16'h8195, 1'b1);
        repeat (8) applyStimulus(16'h1234, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checkOutput("short glimpse active", dut_act[i], 0);
            checkOutput("short glimpse led", dut_led[i], 16'h1234);
        end

        // Password of a disabled mode never selects it.
        for (int c = 1; c <= 20; c++) begin
            applyStimulus(16'h0000, (c % 4) == 0);
        end
        for (int i = 0; i < 2; i++) begin
            checkOutput("disabled mode active", dut_act[i], 0);
            checkOutput("disabled mode led", dut_led[i], 16'h0000);
        end

        // Pending switch abandoned before the frame strobe.
        repeat (6) applyStimulus(16'h2265, 1'b0);
        checkOutput("abandon pending set", dut_pend[0], 1);
        for (int c = 1; c <= 8; c++) begin
            applyStimulus(16'h1234, c == 3 || c == 6);
            if (c == 1) checkOutput("fa0 mode2 commit", dut_act[1], 2);
            if (c == 2) checkOutput("abandon pending cleared", dut_pend[0], 0);
            if (c == 3) checkOutput("abandon no pulse", dut_chg[0], 0);
        end
        checkOutput("abandon stays idle", dut_act[0], 0);
        checkOutput("fa0 back to idle", dut_act[1], 0);

        // Mode 4, then its enable drops and it is left through the debounce path.
        for (int c = 1; c <= 12; c++) applyStimulus(16'h8195, c == 10);
        checkOutput("mode4 active", dut_act[0], 4);
        checkOutput("mode4 led", dut_led[0], 16'h4444);
        checkOutput("mode4 oled", dut_oled[0], 16'hD004);
        mode_enable = 4'b0011;
        applyStimulus(16'h8195, 1'b0);
        checkOutput("enable drop holds fa1", dut_act[0], 4);
        checkOutput("enable drop holds fa0", dut_act[1], 4);
        for (int c = 1; c <= 12; c++) applyStimulus(16'h8195, c == 10);
        checkOutput("enable drop to idle", dut_act[0], 0);
        checkOutput("enable drop led sw", dut_led[0], 16'h8195);

        // Reset arriving while a switch is pending discards it silently.
        mode_enable = 4'b1011;
        repeat (6) applyStimulus(16'h138D, 1'b0);
        checkOutput("pre-reset pending", dut_pend[0], 1);
        reset = 1'b1;
        applyStimulus(16'h138D, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checkOutput("mid reset active", dut_act[i], 0);
            checkOutput("mid reset changed", dut_chg[i], 0);
            checkOutput("mid reset pending", dut_pend[i], 0);
        end
        applyStimulus(16'h138D, 1'b0);
        reset = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(16'h1234, 1'b1);
            checkOutput("post reset no pulse", dut_chg[0], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
